mod_unit: RTL and testbench

MOD_UNIT -- requirements
Module: mod_unit

---
 rtl/mod_unit.sv | 82 ++++++++
 tb/tb_mod_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mod_unit.sv
// Unsigned A mod B by radix-4 restoring long division, 2 dividend bits per cycle.
// Operands are sampled continuously; any change restarts the computation.
module mod_unit #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] mod_result
);

   localparam int HALF = WIDTH / 2;
   localparam int CW   = $clog2(HALF + 1);

   typedef enum logic [1:0] {LOAD, ITER, DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a, r_b, r_res;
   logic [WIDTH+1:0] r_rem;
   logic [CW-1:0]    r_cnt;

   logic             w_chg;
   logic [CW:0]      w_shamt;
   logic [1:0]       w_bits;
   logic [WIDTH+1:0] w_r4, w_b1, w_b2, w_b3, w_sub, w_nxt;

   assign w_chg   = (A != r_a) || (B != r_b);
   // Counter counts down, so the pair at 2*(cnt-1) is the next one MSB-first.
   assign w_shamt = {r_cnt - 1'b1, 1'b0};
   assign w_bits  = 2'(r_a >> w_shamt);
   assign w_r4    = (r_rem << 2) | {{WIDTH{1'b0}}, w_bits};
   assign w_b1    = {2'b00, r_b};
   assign w_b2    = {1'b0, r_b, 1'b0};
   assign w_b3    = w_b1 + w_b2;

   always_comb begin
      w_sub = '0;
      if (w_r4 >= w_b3)      w_sub = w_b3;
      else if (w_r4 >= w_b2) w_sub = w_b2;
      else if (w_r4 >= w_b1) w_sub = w_b1;
   end

   assign w_nxt      = w_r4 - w_sub;
   assign mod_result = r_res;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= LOAD;
         r_a     <= '0;
         r_b     <= '0;
         r_rem   <= '0;
         r_cnt   <= '0;
         r_res   <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               r_a     <= A;
               r_b     <= B;
               r_rem   <= '0;
               r_cnt   <= CW'(HALF);
               r_state <= ITER;
            end
            ITER: begin
               if (w_chg) begin
                  r_state <= LOAD;
               end else begin
                  r_rem <= w_nxt;
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == CW'(1)) begin
                     r_res   <= w_nxt[WIDTH-1:0];
                     r_state <= DONE;
                  end
               end
            end
            DONE: if (w_chg) r_state <= LOAD;
            default: r_state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_unit.sv
// Directed and random checks of mod_unit against a plain A % B reference.
module tb_mod_unit;

   localparam int W = 32;

   logic [W-1:0] A, B, mod_result;
   logic         clk, reset;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_prev, cur_a, cur_b;

   mod_unit #(.WIDTH(W)) dut (
      .A(A), .B(B), .clk(clk), .reset(reset), .mod_result(mod_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) ? a : a % b;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // New operands from DONE: one edge back to LOAD, then 17 edges to the result.
   task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      logic [W-1:0] e;
      if (a == cur_a && b == cur_b) return;
      A = a; B = b;
      cur_a = a; cur_b = b;
      e = ref_mod(a, b);
      for (int i = 0; i < 17; i++) begin
         tick();
         chk({tag, "_hold"}, mod_result, exp_prev);
      end
      tick();
      chk(tag, mod_result, e);
      exp_prev = e;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int sel;

      // Basic case out of reset
      reset = 1'b0; A = 35; B = 15;
      #3;
      chk("reset_clear", mod_result, '0);
      #6 reset = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("basic_pre", mod_result, '0);
      end
      tick();
      chk("basic_t175", {31'd0, ($time == 176)}, 32'd1);
      chk("basic", mod_result, 32'd5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("basic_stay", mod_result, 32'd5);
      end
      exp_prev = 5; cur_a = 35; cur_b = 15;

      apply(32'hFFFF_FFFF, 32'd1,          "ff_div1");
      apply(32'hFFFF_FFFF, 32'hFFFF_FFFE,  "ff_divfe");
      apply(32'd7,   32'd9, "a_lt_b");
      apply(32'd9,   32'd9, "a_eq_b");
      apply(32'd0,   32'd5, "a_zero");
      apply(32'd123, 32'd0, "b_zero");

      // Reset mid-computation clears the output at once, then full latency
      A = 100; B = 7; cur_a = 100; cur_b = 7;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("pre_rst_hold", mod_result, exp_prev);
      end
      #2 reset = 1'b0;
      #1 chk("async_rst", mod_result, '0);
      A = 1000; B = 7;
      #1 reset = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("rst_pre", mod_result, '0);
      end
      tick();
      chk("rst_recompute", mod_result, 32'd6);
      exp_prev = 6; cur_a = 1000; cur_b = 7;

      // Operand change at ITER cycle 8: abort, keep old value, restart
      A = 35; B = 15;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("abort_hold1", mod_result, 32'd6);
      end
      B = 4;
      for (int i = 0; i < 17; i++) begin
         tick();
         chk("abort_hold2", mod_result, 32'd6);
      end
      tick();
      chk("abort_restart", mod_result, 32'd3);
      exp_prev = 3; cur_a = 35; cur_b = 4;

      // Random pairs with a spread of divisor magnitudes
      for (int n = 0; n < 1000; n++) begin
         ra  = $urandom;
         sel = $urandom_range(0, 4);
         case (sel)
            0: rb = $urandom;
            1: rb = $urandom >> $urandom_range(1, 31);
            2: rb = $urandom_range(0, 15);
            3: rb = ra + 32'($urandom_range(0, 2)) - 32'd1;
            default: rb = $urandom & 32'h0000_FFFF;
         endcase
         if (n % 7 == 0) ra = ra >> $urandom_range(0, 31);
         apply(ra, rb, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
